// File: rtl/data_memory_pkg.sv
// Shared definitions for the block-oriented data memory and the data cache
// that sits in front of it: line geometry, access latency and FSM states.
package data_memory_pkg;

    localparam int MEM_LINE_W   = 256;
    localparam int MEM_DEPTH    = 512;
    localparam int MEM_ADDR_W   = 32;
    localparam int MEM_LATENCY  = 10;
    localparam int MEM_OFFSET_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/data_memory.sv
// Off-chip line memory model: one cache line per request, completed with a
// single-cycle ack after a fixed latency. Contents survive reset.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int LINE_W  = MEM_LINE_W,
    parameter int DEPTH   = MEM_DEPTH,
    parameter int ADDR_W  = MEM_ADDR_W,
    parameter int LATENCY = MEM_LATENCY
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY);

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    mem_state_e        state_q;
    logic [CNT_W-1:0]  count_q;
    logic              ack_q;
    logic [IDX_W-1:0]  line_idx_s;
    logic              wr_en_s;
    logic              unused_addr_s;

    assign line_idx_s    = addr_i[MEM_OFFSET_W +: IDX_W];
    assign unused_addr_s = ^{addr_i[ADDR_W-1:MEM_OFFSET_W+IDX_W], addr_i[MEM_OFFSET_W-1:0]};

    // The write lands on the ack edge only; a reset clears ack_q and so drops it.
    assign wr_en_s = (state_q == ST_WAIT) && ack_q && write_i;

    // Request FSM: accept, count out the latency, pulse ack, then retire.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            count_q <= {CNT_W{1'b0}};
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ack_q   <= 1'b0;
                    count_q <= {CNT_W{1'b0}};
                    if (enable_i) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (ack_q) begin
                        state_q <= ST_IDLE;
                        count_q <= {CNT_W{1'b0}};
                        ack_q   <= 1'b0;
                    end else if (!enable_i) begin
                        state_q <= ST_IDLE;
                        count_q <= {CNT_W{1'b0}};
                        ack_q   <= 1'b0;
                    end else if (count_q == CNT_W'(LATENCY - 1)) begin
                        ack_q   <= 1'b1;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    count_q <= {CNT_W{1'b0}};
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Line storage; deliberately not reset so preloaded contents persist.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            memory[line_idx_s] <= data_i;
        end
    end

    assign ack_o  = ack_q;
    assign data_o = memory[line_idx_s];

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed scenarios plus random traffic
// checked against a line-array reference model.
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int LAT = MEM_LATENCY;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [31:0]  addr_i = 32'h0;
    logic [255:0] data_i = 256'h0;
    logic         enable_i = 1'b0;
    logic         write_i = 1'b0;
    logic         ack_o;
    logic [255:0] data_o;

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           wr;
        int unsigned  idx;
        logic [255:0] data;
        int unsigned  ack_cyc;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [255:0] model_mem [0:511];
    int unsigned  cyc = 0;
    int unsigned  total_cnt = 0;
    int unsigned  pass_cnt = 0;
    bit           prev_ack = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic int unsigned idx_of(input logic [31:0] a);
        return int'(a[13:5]);
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (ack_o) begin
            check(!prev_ack, "ack_not_consecutive", {255'h0, prev_ack}, 256'h0);
            prev_ack = 1'b1;
            if (sb_q.size() == 0) begin
                check(1'b0, "unexpected_ack", 256'h1, 256'h0);
            end else begin
                mon_e = sb_q.pop_front();
                check(cyc == mon_e.ack_cyc, "ack_timing", 256'(cyc), 256'(mon_e.ack_cyc));
                if (!mon_e.wr) begin
                    check(data_o === mon_e.data, "read_data", data_o, mon_e.data);
                end else begin
                    @(posedge clk_i);
                    #1;
                    check(dut.memory[mon_e.idx] === mon_e.data, "write_data", dut.memory[mon_e.idx], mon_e.data);
                end
            end
        end else begin
            prev_ack = 1'b0;
        end
    end

    // Called just after a rising edge; the request is accepted at the next edge.
    task automatic start_req(input bit wr, input logic [31:0] a, input logic [255:0] d, input bit expect_ack);
        exp_t e;
        write_i  = wr;
        addr_i   = a;
        data_i   = d;
        enable_i = 1'b1;
        if (expect_ack) begin
            e.wr      = wr;
            e.idx     = idx_of(a);
            e.ack_cyc = cyc + 1 + LAT;
            if (wr) model_mem[e.idx] = d;
            e.data    = model_mem[e.idx];
            sb_q.push_back(e);
        end
    endtask

    // Waits for the ack pulse and returns just after the ack edge.
    task automatic wait_ack();
        bit seen = 1'b0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk_i);
            if (ack_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check(1'b0, "ack_timeout", 256'h0, 256'h1);
            sb_q.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d);
        start_req(wr, a, d, 1'b1);
        wait_ack();
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            model_mem[i]  = rand_line();
            dut.memory[i] = model_mem[i];
        end
        model_mem[0]  = 256'h5;
        dut.memory[0] = 256'h5;

        #12;
        check(ack_o == 1'b0, "reset_ack", {255'h0, ack_o}, 256'h0);
        check(dut.state_q == ST_IDLE, "reset_state", 256'(dut.state_q), 256'(ST_IDLE));
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Read latency on preloaded line 0.
        do_req(1'b0, 32'h0, 256'h0);

        // Write then read of the same line through different offsets.
        do_req(1'b1, 32'h20, 256'hDEAD_BEEF);
        do_req(1'b0, 32'h3F, 256'h0);

        // Back-to-back reads with enable held high across the ack edge.
        start_req(1'b0, 32'h0, 256'h0, 1'b1);
        wait_ack();
        start_req(1'b0, 32'h400, 256'h0, 1'b1);
        wait_ack();
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;

        // Abort: enable dropped before the ack, write must not land.
        start_req(1'b1, 32'h60, rand_line(), 1'b0);
        repeat (4) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        check(dut.state_q == ST_IDLE, "abort_state", 256'(dut.state_q), 256'(ST_IDLE));
        check(dut.memory[3] === model_mem[3], "abort_mem", dut.memory[3], model_mem[3]);
        @(posedge clk_i);
        #1;
        do_req(1'b0, 32'h60, 256'h0);

        // Asynchronous reset in the middle of a write.
        start_req(1'b1, 32'h80, rand_line(), 1'b0);
        repeat (7) @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        check(ack_o == 1'b0, "rst_ack", {255'h0, ack_o}, 256'h0);
        check(dut.state_q == ST_IDLE, "rst_state", 256'(dut.state_q), 256'(ST_IDLE));
        check(dut.count_q == 4'd0, "rst_count", 256'(dut.count_q), 256'h0);
        enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        check(dut.memory[4] === model_mem[4], "rst_mem", dut.memory[4], model_mem[4]);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        do_req(1'b0, 32'h80, 256'h0);

        // Aliasing: upper address bits are ignored.
        do_req(1'b1, 32'h4000, 256'hA11A5);
        do_req(1'b0, 32'h0, 256'h0);

        // Random traffic, biased towards a small window of lines to hit reuse.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[13:5] = 9'($urandom_range(0, 7));
            do_req(1'($urandom_range(0, 1)), a, rand_line());
        end

        repeat (5) @(posedge clk_i);
        check(sb_q.size() == 0, "scoreboard_drained", 256'(sb_q.size()), 256'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Off-chip, block-oriented data memory model sitting behind the CPU's write-back data cache; one 256-bit cache line per access.
- Accepts one request at a time over an enable/ack handshake and completes it after a fixed multi-cycle latency.
- The `memory` array is preloaded and read through hierarchical paths by the bench, including the cache-flush write-back.

Parameters:
- LINE_W, 256, data width in bits (one cache line).
- DEPTH, 512, number of lines (16 KB).
- ADDR_W, 32, byte-address width.
- LATENCY, 10, cycles from request acceptance to the ack cycle; must be >= 2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- addr_i  in  ADDR_W  byte address; line index = addr_i[13:5]; bits [4:0] and [31:14] ignored.
- data_i  in  LINE_W  write line.
- enable_i  in  1  request valid; held high until ack.
- write_i  in  1  1 = write, 0 = read; held stable with enable_i.
- ack_o  out  1  one-cycle completion pulse.
- data_o  out  LINE_W  read line.

Behaviour:
- Storage: reg array `memory[0:DEPTH-1]`, LINE_W wide, exactly this name, hierarchically writable. Reset never clears it; contents are undefined until written or preloaded.
- Reset (rst_i low, any time, asynchronous): state goes to IDLE, count to 0, ack_o to 0. An in-flight write is dropped and memory is untouched.
- States are IDLE and WAIT.
  - IDLE: on an edge with enable_i=1, go to WAIT and set count=0. Otherwise stay; ack_o=0.
  - WAIT with enable_i=1: count increments each edge. ack_o is registered and goes high at the edge where count reaches LATENCY-1. That is LATENCY edges after the acceptance edge.
  - Ack edge: the following edge while ack_o=1. If write_i=1, memory[addr_i[13:5]] <= data_i. State returns to IDLE, count clears, ack_o falls. enable_i is ignored at this edge.
  - WAIT with enable_i=0 at any edge: abort to IDLE, count=0, no write, no ack.
- data_o = memory[addr_i[13:5]], combinational. It is guaranteed valid only while ack_o=1 on a read; the requester samples it at the ack edge.
- Requester must hold addr_i, data_i and write_i stable from acceptance through the ack edge.
- Back-to-back requests: if enable_i is still high in the first IDLE cycle after ack, a new request is accepted at that edge. Minimum request-to-request spacing is LATENCY+2 edges.
- A write followed by a read of the same line returns the new data.
- Address aliasing: any addr_i with equal bits [13:5] maps to the same line.
- ack_o is never high for two consecutive cycles.

Decomposition:
- Shared package (e.g. mem_pkg) holds LINE_W, DEPTH, LATENCY, the line-offset width (5) and the IDLE/WAIT state enum. The dcache uses the same line width and offset.
- No sub-module is needed: one module with the array, a 2-state FSM and a $clog2(LATENCY)-bit counter.

Test Plan:
- Read latency: preload memory[0]=256'h5; raise enable_i with write_i=0, addr_i=32'h0 at edge E0. Required: ack_o high only in the cycle after E10, data_o=256'h5 in that cycle, ack_o low after E11.
- Write then read: write 256'hDEAD_BEEF to addr 32'h20, then read addr 32'h3F. Required: memory[1]=256'hDEAD_BEEF after the write's ack edge; the read returns the same value (offset bits ignored).
- Abort: enable_i at E0, dropped at E5 with write_i=1. Required: no ack, memory unchanged, state IDLE; a new request at E7 acks after E17.
- Reset mid-WAIT: pull rst_i low between edges during a write at count 6. Required: ack_o=0 immediately without a clock, target line unchanged, accepts a new request after rst_i returns high.
- Back-to-back: enable_i held high across two reads of 32'h0 and 32'h400. Required: acks after E10 and E22, with data memory[0] then memory[32].
- Aliasing: write addr 32'h4000 then read 32'h0. Required: same line (index 0) returns the written data.
